// File: rtl/credit_pkg.sv
// Shared definitions for the credit-based link endpoints.
package credit_pkg;

  // Width needed to hold a credit count in the range 0..max.
  function automatic int unsigned cnt_width(input int unsigned max);
    return $clog2(max + 1);
  endfunction

  // Per-cycle credit counter operation, encoded as {inc, dec}.
  typedef enum logic [1:0] {
    CR_HOLD = 2'b00,
    CR_DEC  = 2'b01,
    CR_INC  = 2'b10,
    CR_BOTH = 2'b11
  } credit_op_e;

endpackage

// File: rtl/credit_counter.sv
// Saturating up/down credit counter with sticky overflow flag.
module credit_counter
  import credit_pkg::*;
#(
  parameter int unsigned MAX = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         inc,
  input  logic                         dec,
  output logic [cnt_width(MAX)-1:0]    cnt,
  output logic                         ovf
);

  localparam int unsigned W = cnt_width(MAX);
  localparam logic [W-1:0] MAX_CNT = W'(MAX);

  logic [W-1:0] cnt_q, cnt_d;
  logic         ovf_q, ovf_d;
  credit_op_e   op;

  // Next count: inc+dec together cancel before any saturation check.
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    op    = credit_op_e'({inc, dec});
    case (op)
      CR_DEC:  cnt_d = cnt_q - W'(1);
      CR_INC: begin
        if (cnt_q == MAX_CNT) ovf_d = 1'b1;
        else                  cnt_d = cnt_q + W'(1);
      end
      default: cnt_d = cnt_q;
    endcase
  end

  // Counter and overflow state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= MAX_CNT;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt = cnt_q;
  assign ovf = ovf_q;

endmodule

// File: rtl/credit_sender.sv
// Transmit endpoint of the credit link: forwards accepted beats as one-cycle
// pulses stamped with a wrapping sequence number, gated by held credits.
module credit_sender
  import credit_pkg::*;
#(
  parameter int unsigned MAX_CREDITS = 8,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned SEQ_W       = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid,
  input  logic [DATA_W-1:0]                   in_data,
  output logic                                in_ready,
  output logic                                out_valid,
  output logic [DATA_W-1:0]                   out_data,
  output logic [SEQ_W-1:0]                    out_seq,
  input  logic                                credit_ret,
  output logic [cnt_width(MAX_CREDITS)-1:0]   credit_cnt,
  output logic                                idle,
  output logic                                err_overflow
);

  localparam int unsigned CNT_W = cnt_width(MAX_CREDITS);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_CREDITS);

  logic              send;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic [SEQ_W-1:0]  out_seq_q,   out_seq_d;
  logic [SEQ_W-1:0]  seq_q,       seq_d;

  credit_counter #(
    .MAX (MAX_CREDITS)
  ) u_credit_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (credit_ret),
    .dec   (send),
    .cnt   (credit_cnt),
    .ovf   (err_overflow)
  );

  // Ready depends only on registered credit state, never on in_valid.
  assign in_ready = (credit_cnt != '0);
  assign send     = in_valid & in_ready;

  // Capture a beat on send; payload and sequence hold otherwise.
  always_comb begin
    out_valid_d = send;
    out_data_d  = out_data_q;
    out_seq_d   = out_seq_q;
    seq_d       = seq_q;
    if (send) begin
      out_data_d = in_data;
      out_seq_d  = seq_q;
      seq_d      = seq_q + SEQ_W'(1);
    end
  end

  // Datapath and sequence counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_seq_q   <= '0;
      seq_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_seq_q   <= out_seq_d;
      seq_q       <= seq_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_seq   = out_seq_q;
  assign idle      = (credit_cnt == MAX_CNT) & ~out_valid_q;

endmodule

// File: tb/tb_credit_sender.sv
// Directed testbench for credit_sender with MAX_CREDITS=8, DATA_W=32, SEQ_W=4.
module tb_credit_sender;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic [3:0]  out_seq;
  logic        credit_ret = 1'b0;
  logic [3:0]  credit_cnt;
  logic        idle;
  logic        err_overflow;

  int checks = 0;
  int passed = 0;

  credit_sender #(
    .MAX_CREDITS (8),
    .DATA_W      (32),
    .SEQ_W       (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_seq      (out_seq),
    .credit_ret   (credit_ret),
    .credit_cnt   (credit_cnt),
    .idle         (idle),
    .err_overflow (err_overflow)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0; credit_ret = 1'b0; in_data = '0;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (credit_cnt !== 4'd8) $display("FAIL reset_cnt got %0d exp 8", credit_cnt); else passed++;
    checks++; if (in_ready !== 1'b1) $display("FAIL reset_ready got %b exp 1", in_ready); else passed++;
    checks++; if (idle !== 1'b1) $display("FAIL reset_idle got %b exp 1", idle); else passed++;
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", out_valid); else passed++;
    checks++; if (err_overflow !== 1'b0) $display("FAIL reset_err got %b exp 0", err_overflow); else passed++;
    checks++; if (out_data !== 32'h0 || out_seq !== 4'd0) $display("FAIL reset_data got %h/%0d exp 0/0", out_data, out_seq); else passed++;
  endtask

  // Eight back-to-back beats drain all credits; the ninth is held.
  task automatic test_burst();
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = 32'hA0 + 32'(i);
      step();
      checks++; if (out_valid !== 1'b1) $display("FAIL burst_valid beat %0d got %b exp 1", i, out_valid); else passed++;
      checks++; if (out_data !== 32'hA0 + 32'(i)) $display("FAIL burst_data beat %0d got %h exp %h", i, out_data, 32'hA0 + 32'(i)); else passed++;
      checks++; if (out_seq !== 4'(i)) $display("FAIL burst_seq beat %0d got %0d exp %0d", i, out_seq, i); else passed++;
      checks++; if (credit_cnt !== 4'(7 - i)) $display("FAIL burst_cnt beat %0d got %0d exp %0d", i, credit_cnt, 7 - i); else passed++;
    end
    checks++; if (in_ready !== 1'b0) $display("FAIL burst_ready_low got %b exp 0", in_ready); else passed++;
    in_data = 32'hA8;
    step();
    checks++; if (out_valid !== 1'b0) $display("FAIL held_valid got %b exp 0", out_valid); else passed++;
    checks++; if (out_data !== 32'hA7 || out_seq !== 4'd7) $display("FAIL held_data got %h/%0d exp a7/7", out_data, out_seq); else passed++;
    checks++; if (credit_cnt !== 4'd0) $display("FAIL held_cnt got %0d exp 0", credit_cnt); else passed++;
  endtask

  // One returned credit releases the held ninth beat.
  task automatic test_credit_return();
    credit_ret = 1'b1;
    step();
    credit_ret = 1'b0;
    checks++; if (credit_cnt !== 4'd1) $display("FAIL ret_cnt got %0d exp 1", credit_cnt); else passed++;
    checks++; if (in_ready !== 1'b1) $display("FAIL ret_ready got %b exp 1", in_ready); else passed++;
    checks++; if (out_valid !== 1'b0) $display("FAIL ret_valid got %b exp 0", out_valid); else passed++;
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_data !== 32'hA8 || out_seq !== 4'd8) $display("FAIL ret_send got %b/%h/%0d exp 1/a8/8", out_valid, out_data, out_seq); else passed++;
    checks++; if (credit_cnt !== 4'd0 || in_ready !== 1'b0) $display("FAIL ret_drain got %0d/%b exp 0/0", credit_cnt, in_ready); else passed++;
  endtask

  // Send and return together keep the count at 3.
  task automatic test_both();
    credit_ret = 1'b1;
    repeat (3) step();
    credit_ret = 1'b0;
    checks++; if (credit_cnt !== 4'd3) $display("FAIL both_pre_cnt got %0d exp 3", credit_cnt); else passed++;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; credit_ret = 1'b1;
      in_data  = 32'hB0 + 32'(i);
      step();
      checks++; if (credit_cnt !== 4'd3) $display("FAIL both_cnt beat %0d got %0d exp 3", i, credit_cnt); else passed++;
      checks++; if (out_valid !== 1'b1 || out_seq !== 4'(9 + i)) $display("FAIL both_beat %0d got %b/%0d exp 1/%0d", i, out_valid, out_seq, 9 + i); else passed++;
    end
    in_valid = 1'b0; credit_ret = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0 || credit_cnt !== 4'd3) $display("FAIL both_post got %b/%0d exp 0/3", out_valid, credit_cnt); else passed++;
  endtask

  // Return at full credit flags overflow only without a simultaneous send.
  task automatic test_overflow();
    do_reset();
    in_valid = 1'b1; credit_ret = 1'b1; in_data = 32'h55;
    step();
    in_valid = 1'b0; credit_ret = 1'b0;
    checks++; if (credit_cnt !== 4'd8 || err_overflow !== 1'b0) $display("FAIL ovf_both got %0d/%b exp 8/0", credit_cnt, err_overflow); else passed++;
    checks++; if (idle !== 1'b0) $display("FAIL ovf_idle_busy got %b exp 0", idle); else passed++;
    step();
    checks++; if (idle !== 1'b1) $display("FAIL ovf_idle got %b exp 1", idle); else passed++;
    credit_ret = 1'b1;
    step();
    credit_ret = 1'b0;
    checks++; if (credit_cnt !== 4'd8 || err_overflow !== 1'b1) $display("FAIL ovf_set got %0d/%b exp 8/1", credit_cnt, err_overflow); else passed++;
    step();
    step();
    checks++; if (err_overflow !== 1'b1) $display("FAIL ovf_sticky got %b exp 1", err_overflow); else passed++;
  endtask

  // Sequence wraps after 16 beats; reset mid-burst clears outputs at once.
  task automatic test_wrap_and_reset();
    do_reset();
    checks++; if (err_overflow !== 1'b0) $display("FAIL wrap_err_cleared got %b exp 0", err_overflow); else passed++;
    for (int i = 0; i < 17; i++) begin
      in_valid = 1'b1; credit_ret = 1'b1;
      in_data  = 32'hC0 + 32'(i);
      step();
      checks++; if (out_seq !== 4'(i % 16) || out_data !== 32'hC0 + 32'(i)) $display("FAIL wrap_beat %0d got %0d/%h exp %0d/%h", i, out_seq, out_data, i % 16, 32'hC0 + 32'(i)); else passed++;
      checks++; if (credit_cnt !== 4'd8 || err_overflow !== 1'b0) $display("FAIL wrap_cnt beat %0d got %0d/%b exp 8/0", i, credit_cnt, err_overflow); else passed++;
    end
    credit_ret = 1'b0;
    step();
    checks++; if (credit_cnt !== 4'd7 || out_valid !== 1'b1) $display("FAIL mid_pre got %0d/%b exp 7/1", credit_cnt, out_valid); else passed++;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_data !== 32'h0 || out_seq !== 4'd0) $display("FAIL mid_rst_out got %b/%h/%0d exp 0/0/0", out_valid, out_data, out_seq); else passed++;
    checks++; if (credit_cnt !== 4'd8 || err_overflow !== 1'b0 || idle !== 1'b1) $display("FAIL mid_rst_cnt got %0d/%b/%b exp 8/0/1", credit_cnt, err_overflow, idle); else passed++;
    rst_n = 1'b1;
    in_data = 32'hD0;
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_seq !== 4'd0 || out_data !== 32'hD0) $display("FAIL post_rst_seq got %b/%0d/%h exp 1/0/d0", out_valid, out_seq, out_data); else passed++;
    checks++; if (credit_cnt !== 4'd7) $display("FAIL post_rst_cnt got %0d exp 7", credit_cnt); else passed++;
  endtask

  initial begin
    test_reset();
    test_burst();
    test_credit_return();
    test_both();
    test_overflow();
    test_wrap_and_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
